triangle_period_writer: RTL and testbench
=========================================

# triangle_period_writer

Bus-side register writer for the triangle wave generator's period interface. Accepts 11-bit period values over a valid/ready handshake and buffers them in a small FIFO. Drains each value as a sequence of nibble writes on a shared 4-bit data bus with one-hot LSEL/HSEL/HHSEL strobes. The generator latches each nibble on the rising CLK edge where its select is high. An optional mode suppresses writes of nibbles that are unchanged since they were last written.

## Interface
- DEPTH, 2: FIFO entries (power of two, ≥2)
- GAP, 0: idle CLK cycles inserted after every strobe (0–7)
- CLK  in  1  system clock; all logic on rising edge
- RST_C  in  1  reset, asynchronous, active-low
- PERIOD  in  11  period value to write; [3:0]→LSEL, [7:4]→HSEL, [10:8]→HHSEL
- VALID  in  1  PERIOD valid
- READY  out  1  FIFO can accept; transfer on rising edge with VALID & READY
- DOUT  out  4  nibble to the generator DIN
- LSEL  out  1  low-nibble write strobe
- HSEL  out  1  mid-nibble write strobe
- HHSEL  out  1  high-bits write strobe; DOUT[3] = 0 during it
- BUSY  out  1  FIFO non-empty or FSM not IDLE

## Operation
- FIFO: DEPTH × 11 bits. Push on VALID & READY. READY = RST_C & ~full. VALID while READY is low is ignored, with no side effects.
- FSM states: IDLE, WR_L, WR_H, WR_HH, WAIT.
- IDLE: when the FIFO is non-empty, pop the head into an 11-bit hold register and go to WR_L.
- WR_L: DOUT = hold[3:0], LSEL = 1 for exactly one cycle.
- WR_H: DOUT = hold[7:4], HSEL = 1 for exactly one cycle.
- WR_HH: DOUT = {1'b0, hold[10:8]}, HHSEL = 1 for exactly one cycle.
- WAIT: after each strobe state, spend GAP cycles with all selects 0 and DOUT held. When GAP = 0, WAIT is bypassed.
- After WR_HH (and its WAIT), go to IDLE. IDLE pops the next entry in the same cycle if one is available.
- All of DOUT and the selects are registered. At most one select is high at a time. DOUT is stable throughout each select-high cycle.
- Asynchronous reset behaviour:
  - DOUT = 0, LSEL = HSEL = HHSEL = 0, BUSY = 0, READY = 0.
  - FIFO empty; FSM = IDLE; hold = 0.
  - A write sequence in progress is abandoned immediately, with no partial completion after release.
- After reset release, READY = 1 combinationally.

## Timing
- From empty and IDLE, push at edge N:
  - LSEL high for cycle N+1→N+2.
  - HSEL high for N+2+GAP → N+3+GAP.
  - HHSEL high for N+3+2·GAP → N+4+2·GAP.
- Back-to-back entries: the next LSEL begins GAP cycles after the HHSEL cycle ends, plus 1 cycle for IDLE.
- Per-entry cost is 4 + 3·GAP cycles.
- Simultaneous push and pop on the same edge is allowed. Count is unchanged, and READY stays high if the FIFO was not full.
- When full, READY falls in the cycle after the filling push. It rises in the cycle after the pop.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- BUSY rises with the first push (registered, edge N+1). BUSY falls in the cycle after the last strobe's WAIT ends with the FIFO empty.

## Configuration
- Macro: TRIANGLE_PERIOD_WRITER_SKIP_EN.
- Defined:
  - Keep three shadow nibbles, each with a valid flag. All flags are cleared by reset.
  - A strobe state is skipped, together with its WAIT, when its flag is set and the shadow equals the corresponding hold field.
  - Shadows and flags update on each strobe that is issued.
  - An entry identical to the shadows is popped and discarded; the FSM spends only its IDLE cycle on it.
  - Strobe order is always L, H, HH among the strobes that are issued.
- Undefined: all three strobes are issued for every entry, and no shadow logic is present.

## Test plan
- Reset with GAP=0: push 0x5A3 at edge N → LSEL with DOUT=3 at N+1, HSEL with DOUT=A at N+2, HHSEL with DOUT=5 at N+3. Selects are never simultaneous. BUSY=0 by N+5.
- GAP=2, DEPTH=2: push 0x7FF, 0x001, 0x400 with VALID held high.
  - READY drops after the second push.
  - Third transfer completes after the first pop.
  - Strobes are spaced 3 cycles apart; the next LSEL follows 3 cycles after the previous HHSEL.
  - All three values arrive in order.
- Assert RST_C low during HSEL of 0x2C4 → selects and DOUT are 0 immediately; after release there are no strobes and BUSY=0.
- Hold VALID high with the FIFO full → READY=0 and the entry is not duplicated. Pushing and popping on the same edge when count=1 leaves count 1.
- SKIP_EN: write 0x123, then 0x1A3, then 0x1A3.
  - First entry: three strobes.
  - Second entry: only HSEL, with DOUT=A.
  - Third entry: no strobes, and BUSY falls 2 cycles after its push.
- SKIP_EN, then reset, then rewrite 0x1A3 → all three strobes are issued again.

Source files
------------

// File: rtl/triangle_period_writer.sv
// triangle_period_writer
//   Buffers 11-bit triangle-generator period values in a small FIFO and
//   writes each one to the generator as nibble strobes on a shared 4-bit bus.
//   The strobe order is LSEL (bits 3:0), then HSEL (bits 7:4), then HHSEL
//   (bits 10:8, with DOUT[3] = 0). GAP idle cycles follow every strobe.
//
//   Optional feature (define TRIANGLE_PERIOD_WRITER_SKIP_EN): the last value
//   written for each nibble is shadowed. A strobe whose nibble is unchanged
//   is skipped together with its gap.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   GAP    idle cycles inserted after every strobe (0..7)
// Ports
//   CLK     system clock, rising edge
//   RST_C   asynchronous active-low reset
//   PERIOD  period value to enqueue
//   VALID   PERIOD valid; transfer on VALID & READY
//   READY   FIFO can accept (low in reset and when full)
//   DOUT    nibble to the generator DIN
//   LSEL    low-nibble strobe
//   HSEL    mid-nibble strobe
//   HHSEL   high-bits strobe
//   BUSY    registered: FIFO non-empty or a write sequence active
module triangle_period_writer #(
  parameter int DEPTH = 2,
  parameter int GAP   = 0
) (
  input  logic        CLK,
  input  logic        RST_C,
  input  logic [10:0] PERIOD,
  input  logic        VALID,
  output logic        READY,
  output logic [3:0]  DOUT,
  output logic        LSEL,
  output logic        HSEL,
  output logic        HHSEL,
  output logic        BUSY
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0] WAIT_LOAD = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

  typedef enum logic [2:0] {
    IDLE,
    WR_L,
    WR_H,
    WR_HH,
    WAIT
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [10:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [10:0]      head;

  state_t           state;
  logic [10:0]      hold;
  logic [2:0]       need_q;
  logic [2:0]       wait_cnt;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign READY = RST_C & ~full;
  assign push  = VALID & READY;
  assign pop   = (state == IDLE) & ~empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= PERIOD;
    end
  end

  always_ff @(posedge CLK or negedge RST_C) begin
    if (!RST_C) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------- strobe selection logic
  // need masks: bit0 = L, bit1 = H, bit2 = HH still to be issued.
  logic [2:0]  head_need;
  logic [2:0]  src_need;
  logic [2:0]  rem_need;
  logic [10:0] src_val;
  state_t      tgt;
  logic [3:0]  tgt_dout;
  logic        advance;

`ifdef TRIANGLE_PERIOD_WRITER_SKIP_EN
  logic [3:0] sh_l;
  logic [3:0] sh_h;
  logic [2:0] sh_hh;
  logic [2:0] sh_v;

  always_comb begin
    head_need    = '1;
    head_need[0] = ~(sh_v[0] && (sh_l  == head[3:0]));
    head_need[1] = ~(sh_v[1] && (sh_h  == head[7:4]));
    head_need[2] = ~(sh_v[2] && (sh_hh == head[10:8]));
  end

  always_ff @(posedge CLK or negedge RST_C) begin
    if (!RST_C) begin
      sh_l  <= '0;
      sh_h  <= '0;
      sh_hh <= '0;
      sh_v  <= '0;
    end else if (advance) begin
      case (tgt)
        WR_L: begin
          sh_l    <= src_val[3:0];
          sh_v[0] <= 1'b1;
        end
        WR_H: begin
          sh_h    <= src_val[7:4];
          sh_v[1] <= 1'b1;
        end
        WR_HH: begin
          sh_hh   <= src_val[10:8];
          sh_v[2] <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  assign head_need = 3'b111;
`endif

  function automatic state_t first_of(input logic [2:0] m);
    if (m[0]) return WR_L;
    else if (m[1]) return WR_H;
    else if (m[2]) return WR_HH;
    else return IDLE;
  endfunction

  // In IDLE the decision is made on the FIFO head (it becomes hold on this
  // edge); elsewhere it is made on hold and the remaining-strobe mask.
  always_comb begin
    src_need = (state == IDLE) ? head_need : need_q;
    src_val  = (state == IDLE) ? head : hold;
    rem_need = src_need & (src_need - 3'd1);
    tgt      = first_of(src_need);
    case (tgt)
      WR_L:    tgt_dout = src_val[3:0];
      WR_H:    tgt_dout = src_val[7:4];
      WR_HH:   tgt_dout = {1'b0, src_val[10:8]};
      default: tgt_dout = DOUT;
    endcase
    case (state)
      IDLE:              advance = ~empty;
      WR_L, WR_H, WR_HH: advance = (GAP == 0);
      WAIT:              advance = (wait_cnt == '0);
      default:           advance = 1'b0;
    endcase
  end

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge CLK or negedge RST_C) begin
    if (!RST_C) begin
      state    <= IDLE;
      hold     <= '0;
      need_q   <= '0;
      wait_cnt <= '0;
      DOUT     <= '0;
      LSEL     <= 1'b0;
      HSEL     <= 1'b0;
      HHSEL    <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      BUSY <= ~empty | (state != IDLE);
      if (pop) begin
        hold <= head;
      end
      if (advance) begin
        state  <= tgt;
        need_q <= rem_need;
        DOUT   <= tgt_dout;
        LSEL   <= (tgt == WR_L);
        HSEL   <= (tgt == WR_H);
        HHSEL  <= (tgt == WR_HH);
      end else begin
        case (state)
          WR_L, WR_H, WR_HH: begin
            state    <= WAIT;
            wait_cnt <= WAIT_LOAD;
            LSEL     <= 1'b0;
            HSEL     <= 1'b0;
            HHSEL    <= 1'b0;
          end
          WAIT:    wait_cnt <= wait_cnt - 3'd1;
          IDLE:    ;
          default: begin
            state <= IDLE;
            LSEL  <= 1'b0;
            HSEL  <= 1'b0;
            HHSEL <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_triangle_period_writer.sv
// Self-checking bench for triangle_period_writer. Two instances share the
// clock: u0 (GAP=0) and u2 (GAP=2), both DEPTH=2. Expected strobes (kind,
// nibble, cycle) are queued as stimulus is issued; per-instance monitors pop
// and compare whenever a select is high.
module tb_triangle_period_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst0, rst2, valid0, valid2, ready0, ready2;
  logic        l0, h0, hh0, l2, h2, hh2, busy0, busy2;
  logic [10:0] per0, per2;
  logic [3:0]  d0, d2;

  triangle_period_writer #(.DEPTH(2), .GAP(0)) u0 (
    .CLK(clk), .RST_C(rst0), .PERIOD(per0), .VALID(valid0), .READY(ready0),
    .DOUT(d0), .LSEL(l0), .HSEL(h0), .HHSEL(hh0), .BUSY(busy0)
  );

  triangle_period_writer #(.DEPTH(2), .GAP(2)) u2 (
    .CLK(clk), .RST_C(rst2), .PERIOD(per2), .VALID(valid2), .READY(ready2),
    .DOUT(d2), .LSEL(l2), .HSEL(h2), .HHSEL(hh2), .BUSY(busy2)
  );

  typedef struct {
    int kind;   // 1 = LSEL, 2 = HSEL, 3 = HHSEL
    int dout;
    int at;     // cycle number seen at the sampling negedge
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_strobe(input int w, input int kind, input int dout, input int at);
    exp_t e;
    e.kind = kind;
    e.dout = dout;
    e.at   = at;
    if (w == 0) q0.push_back(e);
    else        q2.push_back(e);
  endtask

  task automatic mon(input int w, input logic l, input logic h, input logic hh,
                     input logic [3:0] d);
    exp_t e;
    int   k;
    if (l | h | hh) begin
      chk($sformatf("u%0d_onehot", w), int'(l) + int'(h) + int'(hh), 1);
      k = l ? 1 : (h ? 2 : 3);
      if ((w == 0 && q0.size() == 0) || (w == 2 && q2.size() == 0)) begin
        chk($sformatf("u%0d_unexpected_strobe", w), k, 0);
      end else begin
        e = (w == 0) ? q0.pop_front() : q2.pop_front();
        chk($sformatf("u%0d_kind", w), k, e.kind);
        chk($sformatf("u%0d_dout", w), d, e.dout);
        chk($sformatf("u%0d_cycle", w), cyc, e.at);
      end
    end
  endtask

  always @(negedge clk) mon(0, l0, h0, hh0, d0);
  always @(negedge clk) mon(2, l2, h2, hh2, d2);

  // Transfer one value; n returns the cycle of the accepting edge.
  task automatic push(input int w, input logic [10:0] v, output int n);
    int t;
    t = 0;
    @(negedge clk);
    if (w == 0) begin per0 = v; valid0 = 1'b1; end
    else        begin per2 = v; valid2 = 1'b1; end
    while (((w == 0) ? ready0 : ready2) !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("push_accept", (t < 100), 1);
    @(posedge clk);
    #1;
    n = cyc;
    if (w == 0) valid0 = 1'b0;
    else        valid2 = 1'b0;
  endtask

  task automatic at_cycle(input int t);
    int guard;
    guard = 0;
    @(negedge clk);
    while (cyc < t && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  int n, na, nb, nc, nd;

  initial begin
    rst0 = 1'b0; rst2 = 1'b0;
    valid0 = 1'b0; valid2 = 1'b0;
    per0 = '0; per2 = '0;

    // Reset state
    at_cycle(3);
    chk("rst_ready0", ready0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_dout0", d0, 0);
    chk("rst_sel0", {l0, h0, hh0}, 0);
    chk("rst_ready2", ready2, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_sel2", {l2, h2, hh2, d2}, 0);
    rst0 = 1'b1; rst2 = 1'b1;
    #1;
    chk("ready0_after_release", ready0, 1);
    chk("ready2_after_release", ready2, 1);

    // GAP=0 single entry 0x5A3
    push(0, 11'h5A3, n);
    exp_strobe(0, 1, 4'h3, n + 1);
    exp_strobe(0, 2, 4'hA, n + 2);
    exp_strobe(0, 3, 4'h5, n + 3);
    at_cycle(n + 1);
    chk("t1_busy_rise", busy0, 1);
    at_cycle(n + 4);
    chk("t1_busy_hold", busy0, 1);
    at_cycle(n + 5);
    chk("t1_busy_fall", busy0, 0);

    // GAP=2, DEPTH=2 back-to-back with backpressure
    push(2, 11'h7FF, na);
    exp_strobe(2, 1, 4'hF, na + 1);
    exp_strobe(2, 2, 4'hF, na + 4);
    exp_strobe(2, 3, 4'h7, na + 7);
    exp_strobe(2, 1, 4'h1, na + 11);
    exp_strobe(2, 2, 4'h0, na + 14);
    exp_strobe(2, 3, 4'h0, na + 17);
    exp_strobe(2, 1, 4'h0, na + 21);
`ifdef TRIANGLE_PERIOD_WRITER_SKIP_EN
    exp_strobe(2, 3, 4'h4, na + 24);
    exp_strobe(2, 1, 4'hA, na + 28);
    exp_strobe(2, 2, 4'hA, na + 31);
    exp_strobe(2, 3, 4'h0, na + 34);
`else
    exp_strobe(2, 2, 4'h0, na + 24);
    exp_strobe(2, 3, 4'h4, na + 27);
    exp_strobe(2, 1, 4'hA, na + 31);
    exp_strobe(2, 2, 4'hA, na + 34);
    exp_strobe(2, 3, 4'h0, na + 37);
`endif
    push(2, 11'h001, nb);
    chk("t2_push2_edge", nb, na + 1);
    push(2, 11'h400, nc);
    chk("t2_push3_edge", nc, na + 2);
    chk("t2_ready_low_full", ready2, 0);
    push(2, 11'h0AA, nd);
    chk("t2_push4_after_pop", nd, na + 12);
`ifdef TRIANGLE_PERIOD_WRITER_SKIP_EN
    at_cycle(na + 37);
    chk("t2_busy_hold", busy2, 1);
    at_cycle(na + 38);
    chk("t2_busy_fall", busy2, 0);
`else
    at_cycle(na + 40);
    chk("t2_busy_hold", busy2, 1);
    at_cycle(na + 41);
    chk("t2_busy_fall", busy2, 0);
`endif

    // Reset during HSEL of 0x2C4
    push(0, 11'h2C4, n);
    exp_strobe(0, 1, 4'h4, n + 1);
    exp_strobe(0, 2, 4'hC, n + 2);
    at_cycle(n + 2);
    #2 rst0 = 1'b0;
    #1;
    chk("t3_sel_in_reset", {l0, h0, hh0}, 0);
    chk("t3_dout_in_reset", d0, 0);
    chk("t3_ready_in_reset", ready0, 0);
    chk("t3_busy_in_reset", busy0, 0);
    at_cycle(cyc + 2);
    rst0 = 1'b1;
    at_cycle(cyc + 10);
    chk("t3_busy_after", busy0, 0);
    chk("t3_ready_after", ready0, 1);

    // Full FIFO with VALID held; push+pop at count 1
    push(0, 11'h111, na);
    exp_strobe(0, 1, 4'h1, na + 1);
    exp_strobe(0, 2, 4'h1, na + 2);
    exp_strobe(0, 3, 4'h1, na + 3);
    exp_strobe(0, 1, 4'h2, na + 5);
    exp_strobe(0, 2, 4'h2, na + 6);
    exp_strobe(0, 3, 4'h2, na + 7);
    exp_strobe(0, 1, 4'h3, na + 9);
    exp_strobe(0, 2, 4'h3, na + 10);
    exp_strobe(0, 3, 4'h3, na + 11);
    exp_strobe(0, 1, 4'h4, na + 13);
    exp_strobe(0, 2, 4'h4, na + 14);
    exp_strobe(0, 3, 4'h4, na + 15);
    push(0, 11'h222, nb);
    chk("t4_push_pop_edge", nb, na + 1);
    chk("t4_ready_after_push_pop", ready0, 1);
    push(0, 11'h333, nc);
    chk("t4_fill_edge", nc, na + 2);
    chk("t4_ready_full", ready0, 0);
    push(0, 11'h444, nd);
    chk("t4_held_push_edge", nd, na + 6);
    at_cycle(na + 17);
    chk("t4_busy_fall", busy0, 0);

    // Unchanged-nibble sequence 0x123, 0x1A3, 0x1A3
    push(0, 11'h123, na);
    exp_strobe(0, 1, 4'h3, na + 1);
    exp_strobe(0, 2, 4'h2, na + 2);
    exp_strobe(0, 3, 4'h1, na + 3);
    at_cycle(na + 6);
    push(0, 11'h1A3, nb);
`ifdef TRIANGLE_PERIOD_WRITER_SKIP_EN
    exp_strobe(0, 2, 4'hA, nb + 1);
`else
    exp_strobe(0, 1, 4'h3, nb + 1);
    exp_strobe(0, 2, 4'hA, nb + 2);
    exp_strobe(0, 3, 4'h1, nb + 3);
`endif
    at_cycle(nb + 6);
    chk("t5_idle_before_third", busy0, 0);
    push(0, 11'h1A3, nc);
`ifdef TRIANGLE_PERIOD_WRITER_SKIP_EN
    at_cycle(nc + 1);
    chk("t5_busy_third_rise", busy0, 1);
    at_cycle(nc + 2);
    chk("t5_busy_third_fall", busy0, 0);
`else
    exp_strobe(0, 1, 4'h3, nc + 1);
    exp_strobe(0, 2, 4'hA, nc + 2);
    exp_strobe(0, 3, 4'h1, nc + 3);
    at_cycle(nc + 4);
    chk("t5_busy_third_rise", busy0, 1);
    at_cycle(nc + 5);
    chk("t5_busy_third_fall", busy0, 0);
`endif

    // Reset clears any shadow state: 0x1A3 is written in full again
    at_cycle(cyc + 1);
    rst0 = 1'b0;
    at_cycle(cyc + 2);
    rst0 = 1'b1;
    push(0, 11'h1A3, n);
    exp_strobe(0, 1, 4'h3, n + 1);
    exp_strobe(0, 2, 4'hA, n + 2);
    exp_strobe(0, 3, 4'h1, n + 3);
    at_cycle(n + 6);
    chk("t6_busy_fall", busy0, 0);

    chk("q0_drained", q0.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
